// File: rtl/pipe_skid_buffer_if.sv
// Handshake bundle between an upstream stage, the skid buffer and the next stage.
interface pipe_skid_buffer_if #(parameter int WIDTH = 32);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_data;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_data;
  logic             flush;
  logic [1:0]       count;

  // Driver side: supplies words, consumes them, and requests flushes.
  modport master (
    output in_valid, in_data, out_ready, flush,
    input  in_ready, out_valid, out_data, count
  );

  // Buffer side.
  modport slave (
    input  in_valid, in_data, out_ready, flush,
    output in_ready, out_valid, out_data, count
  );
endinterface

// File: rtl/pipe_skid_buffer.sv
// Two-entry skid buffer for a pipeline latch with valid/ready backpressure.
//
//   state   | meaning
//   --------+-----------------------------------------------------------
//   S_EMPTY | nothing held; accepting
//   S_BUSY  | one word in main, presented downstream; still accepting
//   S_FULL  | main presented, skid holds the next word; not accepting
//
// in_ready, out_valid and count are registered copies of the next-state
// decode, so upstream ready never depends combinationally on out_ready.
module pipe_skid_buffer #(
  parameter int WIDTH = 32
) (
  input logic                clk,
  input logic                rst_n,
  pipe_skid_buffer_if.slave  bus
);

  typedef enum logic [1:0] {
    S_EMPTY = 2'd0,
    S_BUSY  = 2'd1,
    S_FULL  = 2'd2
  } state_t;

  state_t           r_state;
  state_t           w_state_nxt;
  logic [WIDTH-1:0] r_main;
  logic [WIDTH-1:0] r_skid;
  logic             r_in_ready;
  logic             r_out_valid;
  logic [1:0]       r_count;
  logic             w_in_fire;
  logic             w_out_fire;
  logic             w_load_main_in;
  logic             w_load_main_skid;
  logic             w_load_skid;

  assign w_in_fire  = bus.in_valid & r_in_ready;
  assign w_out_fire = r_out_valid & bus.out_ready;

  assign bus.in_ready  = r_in_ready;
  assign bus.out_valid = r_out_valid;
  assign bus.out_data  = r_main;
  assign bus.count     = r_count;

  // Next-state and register-load decode; flush overrides every handshake.
  always_comb begin
    w_state_nxt      = r_state;
    w_load_main_in   = 1'b0;
    w_load_main_skid = 1'b0;
    w_load_skid      = 1'b0;
    if (bus.flush) begin
      w_state_nxt = S_EMPTY;
    end else begin
      case (r_state)
        S_EMPTY: begin
          if (w_in_fire) begin
            w_load_main_in = 1'b1;
            w_state_nxt    = S_BUSY;
          end
        end
        S_BUSY: begin
          if (w_in_fire && w_out_fire) begin
            w_load_main_in = 1'b1;
          end else if (w_in_fire) begin
            w_load_skid = 1'b1;
            w_state_nxt = S_FULL;
          end else if (w_out_fire) begin
            w_state_nxt = S_EMPTY;
          end
        end
        S_FULL: begin
          if (w_out_fire) begin
            w_load_main_skid = 1'b1;
            w_state_nxt      = S_BUSY;
          end
        end
        default: w_state_nxt = S_EMPTY;
      endcase
    end
  end

  // State register plus registered output decode of the next state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= S_EMPTY;
      r_in_ready  <= 1'b1;
      r_out_valid <= 1'b0;
      r_count     <= 2'd0;
    end else begin
      r_state     <= w_state_nxt;
      r_in_ready  <= (w_state_nxt != S_FULL);
      r_out_valid <= (w_state_nxt != S_EMPTY);
      case (w_state_nxt)
        S_BUSY:  r_count <= 2'd1;
        S_FULL:  r_count <= 2'd2;
        default: r_count <= 2'd0;
      endcase
    end
  end

  // Data registers: main only ever loads from an accepted word or the skid.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_main <= '0;
      r_skid <= '0;
    end else begin
      if (w_load_main_in) begin
        r_main <= bus.in_data;
      end else if (w_load_main_skid) begin
        r_main <= r_skid;
      end
      if (w_load_skid) begin
        r_skid <= bus.in_data;
      end
    end
  end

endmodule

// File: doc/pipe_skid_buffer.md
Name: pipe_skid_buffer

Overview:
- Two-entry skid buffer forming the receiving end of a CPU pipeline latch, with valid/ready backpressure.
- A plain stage register captures its input unconditionally every clock; this block accepts a word only on handshake and holds it until the next stage takes it.
- Sits between pipeline stages so a downstream stall never drops data and never forces a combinational ready path upstream.
- Full throughput (one word per clock) when not stalled.

Parameters:
- WIDTH, 32, data word width in bits.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- in_valid  input  1  upstream word present on in_data.
- in_ready  output  1  block can accept a word this cycle; driven from a register, no combinational path from out_ready.
- in_data  input  WIDTH  upstream word.
- out_valid  output  1  out_data holds a valid word.
- out_ready  input  1  downstream accepts the word this cycle.
- out_data  output  WIDTH  word presented downstream; driven directly from the main register.
- flush  input  1  synchronous discard of all held words, for branch mispredict or exception.
- count  output  2  occupancy: 0, 1 or 2.

Behaviour:
- Handshakes: in_fire = in_valid & in_ready; out_fire = out_valid & out_ready. All state updates occur on the rising clk edge.
- Reset (rst_n low, asynchronous):
  - state = EMPTY, in_ready = 1, out_valid = 0, count = 0.
  - main and skid registers = 0, so out_data = 0.
- Registered output decode:
  - EMPTY: out_valid 0, in_ready 1, count 0.
  - BUSY: out_valid 1, in_ready 1, count 1.
  - FULL: out_valid 1, in_ready 0, count 2.
- Transitions (flush not asserted):
  - EMPTY, in_fire: main <= in_data; go to BUSY.
  - EMPTY, no in_fire: stay in EMPTY.
  - BUSY, in_fire & out_fire: main <= in_data; stay in BUSY.
  - BUSY, in_fire only: skid <= in_data; go to FULL.
  - BUSY, out_fire only: go to EMPTY.
  - BUSY, neither: hold.
  - FULL, out_fire: main <= skid; go to BUSY. in_fire is impossible because in_ready = 0.
  - FULL, no out_fire: hold.
- Latency and ordering:
  - One cycle from in_fire to out_valid for the same word.
  - Words leave strictly in arrival order.
  - No bubble in steady-state streaming with out_ready held high.
- Stability: while out_valid = 1 and out_ready = 0, out_data and out_valid must not change, except under flush or reset.
- Flush (highest priority after reset):
  - Next state = EMPTY; in_ready = 1 and out_valid = 0 from the next cycle.
  - Any in_fire or out_fire in the flush cycle is ignored; the incoming word is dropped.
  - Data registers need not be cleared.
- Reset mid-operation: immediate return to the reset values above, regardless of state or handshake.
- X-safety: in_data and skid contents are don't-care when not captured; main must never be loaded without in_fire or a skid transfer.

Test Plan:
- Reset then stream: hold rst_n low 3 cycles, release. Drive in_valid = 1 with in_data = 1,2,3,4 on consecutive cycles and out_ready = 1. Required: out_valid rises one cycle after the first word; out_data = 1,2,3,4 on consecutive cycles; in_ready stays 1; count stays 1.
- Stall fill: with out_ready = 0, send 0xA then 0xB. Required: count goes 1 then 2; in_ready = 0 after the second capture; out_data holds 0xA and stays stable; 0xC held on in_data is not accepted.
- Drain after stall: from FULL (0xA, 0xB), raise out_ready for 2 cycles with in_valid = 0. Required: out_data = 0xA then 0xB; out_valid = 0 and count = 0 in the third cycle; in_ready = 1 after the first out_fire.
- Simultaneous in/out in BUSY: main = 0x5, in_valid = 1 with 0x6, out_ready = 1. Required: 0x5 consumed, out_data = 0x6 next cycle, count stays 1, no transition to FULL.
- Flush: from FULL, assert flush for one cycle while in_valid = 1 with 0x7 and out_ready = 1. Required: next cycle out_valid = 0, count = 0, in_ready = 1; neither 0x7 nor the held words ever appear on out_data.
- Async reset mid-stall: in FULL, pulse rst_n low between clock edges. Required: out_valid = 0, in_ready = 1, count = 0 and out_data = 0 immediately, before the next clk edge.
